// File: rtl/simd_acc_pkg.sv
// Shared types and constants for the SIMD adder-tree accumulator/collector.
// Holds the FSM states, level codes, lane counts and the active-lane mask helper.
package simd_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] LVL_L1 = 2'd0;
    localparam logic [1:0] LVL_L2 = 2'd1;
    localparam logic [1:0] LVL_L3 = 2'd2;

    localparam int NUM_L1 = 16;
    localparam int NUM_L2 = 4;
    localparam int NUM_L3 = 1;

    // Reserved code 3 falls through to the single-lane L3 view.
    function automatic logic [NUM_L1-1:0] lane_mask(input logic [1:0] sel);
        case (sel)
            LVL_L1:  return 16'hFFFF;
            LVL_L2:  return 16'h000F;
            default: return 16'h0001;
        endcase
    endfunction

endpackage

// File: rtl/simd_acc_collector_if.sv
// Tree-output beats in, finished accumulator result out via valid/ready.
// Master drives the job and beats (upstream/bench); slave is the collector.
interface simd_acc_collector_if #(
    parameter int MAC_BW = 8,
    parameter int ACC_BW = 32,
    parameter int LEN_BW = 16
);
    import simd_acc_pkg::*;

    logic                                start;
    logic [1:0]                          sel;
    logic [LEN_BW-1:0]                   len;
    logic                                in_valid;
    logic [NUM_L1-1:0][2*MAC_BW-1:0]     iL1;
    logic [NUM_L2-1:0][2*MAC_BW-1:0]     iL2;
    logic [2*MAC_BW-1:0]                 iL3;
    logic                                out_valid;
    logic                                out_ready;
    logic [NUM_L1-1:0][ACC_BW-1:0]       oAcc;
    logic                                ovf;
    logic                                drop;
    logic                                busy;

    modport master (
        output start, sel, len, in_valid, iL1, iL2, iL3, out_ready,
        input  out_valid, oAcc, ovf, drop, busy
    );

    modport slave (
        input  start, sel, len, in_valid, iL1, iL2, iL3, out_ready,
        output out_valid, oAcc, ovf, drop, busy
    );

endinterface

// File: rtl/simd_acc_lane.sv
// One accumulator lane: registered modulo-2^ACC_BW sum, 1-cycle update when en_i.
// carry_o is the combinational carry of the pending add; clr_i wins over en_i.
module simd_acc_lane #(
    parameter int MAC_BW = 8,
    parameter int ACC_BW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [2*MAC_BW-1:0] add_i,
    output logic [ACC_BW-1:0]   sum_o,
    output logic                carry_o
);

    logic [ACC_BW-1:0] sum_q;
    logic [ACC_BW-1:0] sum_d;
    logic [ACC_BW:0]   wide_sum;

    assign wide_sum = {1'b0, sum_q} + (ACC_BW+1)'(add_i);
    assign carry_o  = wide_sum[ACC_BW];

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = wide_sum[ACC_BW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/simd_acc_collector.sv
// Accumulates len beats of one adder-tree level; out_valid the cycle after the last beat.
// Result held in HOLD until out_ready; beats outside ACC are discarded and flagged on drop.
module simd_acc_collector #(
    parameter int MAC_BW = 8,
    parameter int ACC_BW = 32,
    parameter int LEN_BW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    simd_acc_collector_if.slave   bus
);
    import simd_acc_pkg::*;

    state_t              state_q, state_d;
    logic [LEN_BW-1:0]   cnt_q, cnt_d;
    logic [LEN_BW-1:0]   len_q, len_d;
    logic [1:0]          sel_q, sel_d;
    logic                ovf_q, ovf_d;
    logic                drop_q, drop_d;

    logic                        clr;
    logic                        acc_beat;
    logic                        carry_any;
    logic [NUM_L1-1:0]           mask;
    logic [NUM_L1-1:0]           lane_en;
    logic [NUM_L1-1:0]           carry_w;
    logic [NUM_L1-1:0][2*MAC_BW-1:0] addend_w;
    logic [NUM_L1-1:0][ACC_BW-1:0]   sum_w;

    assign mask      = lane_mask(sel_q);
    assign acc_beat  = (state_q == ACC) && bus.in_valid;
    assign lane_en   = {NUM_L1{acc_beat}} & mask;
    assign carry_any = |(carry_w & mask);

    // Steering: lane g only ever sees the tree outputs that exist for it.
    for (genvar g = 0; g < NUM_L1; g++) begin : g_lane
        if (g == 0) begin : g_l0
            assign addend_w[g] = (sel_q == LVL_L1) ? bus.iL1[g] :
                                 (sel_q == LVL_L2) ? bus.iL2[g] : bus.iL3;
        end else if (g < NUM_L2) begin : g_l2
            assign addend_w[g] = (sel_q == LVL_L1) ? bus.iL1[g] :
                                 (sel_q == LVL_L2) ? bus.iL2[g] : '0;
        end else begin : g_l1
            assign addend_w[g] = (sel_q == LVL_L1) ? bus.iL1[g] : '0;
        end

        simd_acc_lane #(
            .MAC_BW (MAC_BW),
            .ACC_BW (ACC_BW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clr),
            .en_i    (lane_en[g]),
            .add_i   (addend_w[g]),
            .sum_o   (sum_w[g]),
            .carry_o (carry_w[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sel_d   = sel_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        clr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) drop_d = 1'b1;
                if (bus.start) begin
                    sel_d   = bus.sel;
                    len_d   = (bus.len == '0) ? LEN_BW'(1) : bus.len;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    clr     = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (bus.in_valid) begin
                    ovf_d = ovf_q | carry_any;
                    cnt_d = cnt_q + LEN_BW'(1);
                    if (cnt_q == len_q - LEN_BW'(1)) state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.in_valid) drop_d = 1'b1;
                if (bus.out_ready) begin
                    if (bus.start) begin
                        sel_d   = bus.sel;
                        len_d   = (bus.len == '0) ? LEN_BW'(1) : bus.len;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        clr     = 1'b1;
                        state_d = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.oAcc      = sum_w;
    assign bus.ovf       = ovf_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_simd_acc_collector.sv
// Directed bench for simd_acc_collector: table of single jobs plus hand-written
// sequences for overflow, back-to-back handshake, drop and mid-job reset.
module tb_simd_acc_collector;
    import simd_acc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simd_acc_collector_if #(.MAC_BW(8), .ACC_BW(32), .LEN_BW(16)) bus_a ();
    simd_acc_collector_if #(.MAC_BW(8), .ACC_BW(17), .LEN_BW(16)) bus_b ();

    simd_acc_collector #(.MAC_BW(8), .ACC_BW(32), .LEN_BW(16)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    simd_acc_collector #(.MAC_BW(8), .ACC_BW(17), .LEN_BW(16)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] len;
        logic [15:0] base;   // lane i value = base + i*step on every level
        logic [15:0] step;
        bit          gap;    // idle cycle between beats
        int          stall;  // cycles with out_ready low in HOLD
        logic [31:0] e0;
        logic [31:0] e3;
        logic [31:0] e15;
    } vec_t;

    vec_t vt [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [15:0] base, input logic [15:0] step);
        for (int i = 0; i < 16; i++) bus_a.iL1[i] = base + 16'(i) * step;
        for (int i = 0; i < 4; i++)  bus_a.iL2[i] = base + 16'(i) * step;
        bus_a.iL3 = base;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb;
        logic [31:0] held0;
        nb = (v.len == 16'd0) ? 1 : int'(v.len);
        bus_a.start = 1'b1; bus_a.sel = v.sel; bus_a.len = v.len;
        tick();
        bus_a.start = 1'b0;
        check($sformatf("v%0d busy_after_start", idx), 64'(bus_a.busy), 64'd1);
        for (int b = 0; b < nb; b++) begin
            if (v.gap && b > 0) begin
                bus_a.in_valid = 1'b0;
                tick();
            end
            drive_a(v.base, v.step);
            bus_a.in_valid = 1'b1;
            tick();
            bus_a.in_valid = 1'b0;
            if (b < nb - 1)
                check($sformatf("v%0d no_early_valid b%0d", idx, b), 64'(bus_a.out_valid), 64'd0);
        end
        check($sformatf("v%0d out_valid", idx), 64'(bus_a.out_valid), 64'd1);
        check($sformatf("v%0d lane0", idx), 64'(bus_a.oAcc[0]), 64'(v.e0));
        check($sformatf("v%0d lane3", idx), 64'(bus_a.oAcc[3]), 64'(v.e3));
        check($sformatf("v%0d lane15", idx), 64'(bus_a.oAcc[15]), 64'(v.e15));
        check($sformatf("v%0d ovf", idx), 64'(bus_a.ovf), 64'd0);
        held0 = v.e0;
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < v.stall; k++) begin
            drive_a(16'h1234, 16'h0);
            tick();
            check($sformatf("v%0d stall_valid k%0d", idx, k), 64'(bus_a.out_valid), 64'd1);
            check($sformatf("v%0d stall_lane0 k%0d", idx, k), 64'(bus_a.oAcc[0]), 64'(held0));
        end
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check($sformatf("v%0d valid_after_hs", idx), 64'(bus_a.out_valid), 64'd0);
        check($sformatf("v%0d busy_after_hs", idx), 64'(bus_a.busy), 64'd0);
        check($sformatf("v%0d lane3_kept", idx), 64'(bus_a.oAcc[3]), 64'(v.e3));
    endtask

    initial begin
        int hits;
        vt[0] = '{sel: 2'd0, len: 16'd3, base: 16'd1,      step: 16'd1,   gap: 1'b0, stall: 0,
                  e0: 32'd3,      e3: 32'd12,     e15: 32'd48};
        vt[1] = '{sel: 2'd1, len: 16'd2, base: 16'd100,    step: 16'd100, gap: 1'b1, stall: 4,
                  e0: 32'd200,    e3: 32'd800,    e15: 32'd0};
        vt[2] = '{sel: 2'd2, len: 16'd0, base: 16'hFFFF,   step: 16'd0,   gap: 1'b0, stall: 1,
                  e0: 32'hFFFF,   e3: 32'd0,      e15: 32'd0};
        vt[3] = '{sel: 2'd3, len: 16'd2, base: 16'd5,      step: 16'd1,   gap: 1'b1, stall: 0,
                  e0: 32'd10,     e3: 32'd0,      e15: 32'd0};
        vt[4] = '{sel: 2'd0, len: 16'd1, base: 16'hFFFF,   step: 16'd0,   gap: 1'b0, stall: 2,
                  e0: 32'hFFFF,   e3: 32'hFFFF,   e15: 32'hFFFF};

        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.sel = '0; bus_a.len = '0; bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b0; drive_a(16'd0, 16'd0);
        bus_b.start = 1'b0; bus_b.sel = '0; bus_b.len = '0; bus_b.in_valid = 1'b0;
        bus_b.out_ready = 1'b0; bus_b.iL1 = '0; bus_b.iL2 = '0; bus_b.iL3 = '0;
        tick();
        tick();
        check("rst out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst busy", 64'(bus_a.busy), 64'd0);
        check("rst ovf", 64'(bus_a.ovf), 64'd0);
        check("rst drop", 64'(bus_a.drop), 64'd0);
        check("rst oacc_or", 64'(|bus_a.oAcc), 64'd0);
        check("rst b busy", 64'(bus_b.busy), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(i, vt[i]);
        check("drop_still_clear", 64'(bus_a.drop), 64'd0);

        // Modulo wrap on the 17-bit instance: 3*0xFFFF = 0x2FFFD -> 0x0FFFD with ovf.
        bus_b.start = 1'b1; bus_b.sel = 2'd2; bus_b.len = 16'd3;
        tick();
        bus_b.start = 1'b0;
        bus_b.iL3 = 16'hFFFF;
        for (int b = 0; b < 3; b++) begin
            bus_b.in_valid = 1'b1;
            tick();
        end
        bus_b.in_valid = 1'b0;
        check("ovf17 out_valid", 64'(bus_b.out_valid), 64'd1);
        check("ovf17 lane0", 64'(bus_b.oAcc[0]), 64'h0FFFD);
        check("ovf17 ovf", 64'(bus_b.ovf), 64'd1);
        tick();
        check("ovf17 ovf_held", 64'(bus_b.ovf), 64'd1);
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
        bus_b.start = 1'b1; bus_b.sel = 2'd2; bus_b.len = 16'd1;
        tick();
        bus_b.start = 1'b0;
        check("ovf17 next_job_ovf_clr", 64'(bus_b.ovf), 64'd0);
        bus_b.iL3 = 16'd1; bus_b.in_valid = 1'b1;
        tick();
        bus_b.in_valid = 1'b0;
        check("ovf17 next_lane0", 64'(bus_b.oAcc[0]), 64'd1);
        check("ovf17 next_ovf", 64'(bus_b.ovf), 64'd0);
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;

        // Back-to-back: handshake and new start in the same cycle.
        bus_a.start = 1'b1; bus_a.sel = 2'd1; bus_a.len = 16'd1;
        tick();
        bus_a.start = 1'b0;
        drive_a(16'd7, 16'd0); bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        check("b2b first lane0", 64'(bus_a.oAcc[0]), 64'd7);
        bus_a.out_ready = 1'b1; bus_a.start = 1'b1; bus_a.sel = 2'd0; bus_a.len = 16'd1;
        tick();
        bus_a.out_ready = 1'b0; bus_a.start = 1'b0;
        check("b2b valid_low", 64'(bus_a.out_valid), 64'd0);
        check("b2b busy", 64'(bus_a.busy), 64'd1);
        drive_a(16'd2, 16'd0); bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        check("b2b out_valid", 64'(bus_a.out_valid), 64'd1);
        check("b2b lane0", 64'(bus_a.oAcc[0]), 64'd2);
        check("b2b lane3", 64'(bus_a.oAcc[3]), 64'd2);
        check("b2b lane15", 64'(bus_a.oAcc[15]), 64'd2);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;

        // Stray beat in IDLE.
        drive_a(16'd50, 16'd1); bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        check("idle drop", 64'(bus_a.drop), 64'd1);
        check("idle lane0", 64'(bus_a.oAcc[0]), 64'd2);
        check("idle busy", 64'(bus_a.busy), 64'd0);

        // Reset in the middle of a len=8 job.
        bus_a.start = 1'b1; bus_a.sel = 2'd0; bus_a.len = 16'd8;
        tick();
        bus_a.start = 1'b0;
        drive_a(16'd9, 16'd0);
        for (int b = 0; b < 3; b++) begin
            bus_a.in_valid = 1'b1;
            tick();
        end
        bus_a.in_valid = 1'b0;
        check("mid lane0_partial", 64'(bus_a.oAcc[0]), 64'd27);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 64'(bus_a.out_valid), 64'd0);
        check("mid rst busy", 64'(bus_a.busy), 64'd0);
        check("mid rst drop", 64'(bus_a.drop), 64'd0);
        check("mid rst oacc_or", 64'(|bus_a.oAcc), 64'd0);
        tick();
        rst = 1'b0;
        bus_a.out_ready = 1'b1;
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus_a.out_valid || bus_a.busy) hits++;
        end
        bus_a.out_ready = 1'b0;
        check("mid no_result", 64'(hits), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
